// File: rtl/pong_state_link.sv
`timescale 1ns/1ps
// pong_state_link
//   Frames a game-state snapshot into a byte stream for the board-to-board
//   UART link, and parses/validates frames arriving from the peer board.
//   Frame on the wire: SYNC_BYTE, LEN, payload[0..N-1], SUM
//   where LEN = PAYLOAD_BYTES and SUM = (LEN + sum of payload bytes) mod 256.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous reset, active low
//   send           1-cycle request to transmit tx_payload
//   tx_payload     snapshot to send, byte 0 = bits [7:0], sent first
//   tx_byte        byte offered to the UART TX core
//   tx_byte_valid  tx_byte valid, held until accepted
//   tx_byte_ready  UART TX accepts tx_byte this cycle
//   tx_busy        frame in progress or one frame pending
//   rx_byte        byte from the UART RX core
//   rx_byte_valid  1-cycle strobe qualifying rx_byte
//   rx_payload     last validated payload
//   rx_frame_valid 1-cycle pulse, rx_payload just updated
//   link_ok        a good frame was seen within the last LINK_TIMEOUT cycles
//   err_count      saturating count of rejected frames
//
// TX states
//   state  | meaning
//   T_IDLE | nothing to send
//   T_SYNC | offering SYNC_BYTE
//   T_LEN  | offering LEN
//   T_DATA | offering payload bytes, tx_cnt counts down to the last one
//   T_SUM  | offering the checksum
//
// RX states
//   state  | meaning
//   R_HUNT | looking for SYNC_BYTE, other bytes ignored
//   R_LEN  | expecting LEN
//   R_DATA | collecting payload into the shadow buffer
//   R_SUM  | expecting the checksum

module pong_state_link #(
    parameter int         PAYLOAD_BYTES = 6,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         BYTE_TIMEOUT  = 65000,
    parameter int         LINK_TIMEOUT  = 6500000,
    parameter int         ERR_W         = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         send,
    input  logic [8*PAYLOAD_BYTES-1:0]   tx_payload,
    output logic [7:0]                   tx_byte,
    output logic                         tx_byte_valid,
    input  logic                         tx_byte_ready,
    output logic                         tx_busy,
    input  logic [7:0]                   rx_byte,
    input  logic                         rx_byte_valid,
    output logic [8*PAYLOAD_BYTES-1:0]   rx_payload,
    output logic                         rx_frame_valid,
    output logic                         link_ok,
    output logic [ERR_W-1:0]             err_count
);

    localparam int PW   = 8*PAYLOAD_BYTES;
    localparam int BT_W = $clog2(BYTE_TIMEOUT+1);
    localparam int LT_W = $clog2(LINK_TIMEOUT+1);

    localparam logic [7:0]      LEN_BYTE  = 8'(PAYLOAD_BYTES);
    localparam logic [7:0]      LAST_IDX  = 8'(PAYLOAD_BYTES-1);
    localparam logic [BT_W-1:0] BT_RELOAD = BT_W'(BYTE_TIMEOUT-1);
    localparam logic [LT_W-1:0] LT_RELOAD = LT_W'(LINK_TIMEOUT-1);

    typedef enum logic [2:0] {T_IDLE, T_SYNC, T_LEN, T_DATA, T_SUM} tx_state_t;
    typedef enum logic [1:0] {R_HUNT, R_LEN, R_DATA, R_SUM} rx_state_t;

    // ---------------------------------------------------------------- TX
    tx_state_t      tx_state;
    logic [PW-1:0]  tx_buf;
    logic [7:0]     tx_sum;
    logic [7:0]     tx_cnt;
    logic           tx_pending;
    logic           tx_xfer;

    assign tx_xfer = tx_byte_valid & tx_byte_ready;
    assign tx_busy = (tx_state != T_IDLE) | tx_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state      <= T_IDLE;
            tx_buf        <= '0;
            tx_sum        <= '0;
            tx_cnt        <= '0;
            tx_pending    <= 1'b0;
            tx_byte       <= '0;
            tx_byte_valid <= 1'b0;
        end else begin
            // One request can wait behind the current frame; further ones are dropped.
            if (send && tx_state != T_IDLE)
                tx_pending <= 1'b1;

            case (tx_state)
                T_IDLE: begin
                    if (send) begin
                        tx_buf        <= tx_payload;
                        tx_byte       <= SYNC_BYTE;
                        tx_byte_valid <= 1'b1;
                        tx_state      <= T_SYNC;
                    end
                end
                T_SYNC: begin
                    if (tx_xfer) begin
                        tx_byte  <= LEN_BYTE;
                        tx_state <= T_LEN;
                    end
                end
                T_LEN: begin
                    if (tx_xfer) begin
                        tx_byte  <= tx_buf[7:0];
                        tx_buf   <= tx_buf >> 8;
                        tx_sum   <= LEN_BYTE;
                        tx_cnt   <= LAST_IDX;
                        tx_state <= T_DATA;
                    end
                end
                T_DATA: begin
                    if (tx_xfer) begin
                        tx_sum <= tx_sum + tx_byte;
                        if (tx_cnt == '0) begin
                            tx_byte  <= tx_sum + tx_byte;
                            tx_state <= T_SUM;
                        end else begin
                            tx_byte <= tx_buf[7:0];
                            tx_buf  <= tx_buf >> 8;
                            tx_cnt  <= tx_cnt - 8'd1;
                        end
                    end
                end
                T_SUM: begin
                    if (tx_xfer) begin
                        // A request seen during this frame (or right now) chains
                        // straight into the next SYNC with no idle gap.
                        if (send || tx_pending) begin
                            tx_buf     <= tx_payload;
                            tx_byte    <= SYNC_BYTE;
                            tx_state   <= T_SYNC;
                            tx_pending <= 1'b0;
                        end else begin
                            tx_byte       <= '0;
                            tx_byte_valid <= 1'b0;
                            tx_state      <= T_IDLE;
                        end
                    end
                end
                default: begin
                    tx_byte_valid <= 1'b0;
                    tx_state      <= T_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- RX
    rx_state_t        rx_state;
    logic [PW-1:0]    rx_shadow;
    logic [7:0]       rx_sum;
    logic [7:0]       rx_cnt;
    logic [BT_W-1:0]  byte_tmr;
    logic [LT_W-1:0]  link_tmr;
    logic             rx_timeout;
    logic             len_bad;
    logic             sum_bad;
    logic             sum_good;

    always_comb begin
        rx_timeout = (rx_state != R_HUNT) && !rx_byte_valid && (byte_tmr == '0);
        len_bad    = rx_byte_valid && (rx_state == R_LEN) && (rx_byte != LEN_BYTE);
        sum_bad    = rx_byte_valid && (rx_state == R_SUM) && (rx_byte != rx_sum);
        sum_good   = rx_byte_valid && (rx_state == R_SUM) && (rx_byte == rx_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state       <= R_HUNT;
            rx_shadow      <= '0;
            rx_sum         <= '0;
            rx_cnt         <= '0;
            byte_tmr       <= '0;
            link_tmr       <= '0;
            rx_payload     <= '0;
            rx_frame_valid <= 1'b0;
            link_ok        <= 1'b0;
            err_count      <= '0;
        end else begin
            rx_frame_valid <= 1'b0;

            if ((rx_timeout || len_bad || sum_bad) && err_count != '1)
                err_count <= err_count + 1'b1;

            if (sum_good) begin
                link_ok  <= 1'b1;
                link_tmr <= LT_RELOAD;
            end else if (link_ok) begin
                if (link_tmr == '0)
                    link_ok <= 1'b0;
                else
                    link_tmr <= link_tmr - 1'b1;
            end

            // Inter-byte timer only runs inside a frame; an arriving byte
            // always beats an expiry in the same cycle.
            if (rx_state != R_HUNT && !rx_byte_valid) begin
                if (byte_tmr == '0)
                    rx_state <= R_HUNT;
                else
                    byte_tmr <= byte_tmr - 1'b1;
            end

            if (rx_byte_valid) begin
                byte_tmr <= BT_RELOAD;
                case (rx_state)
                    R_HUNT: begin
                        if (rx_byte == SYNC_BYTE)
                            rx_state <= R_LEN;
                    end
                    R_LEN: begin
                        if (len_bad) begin
                            rx_state <= R_HUNT;
                        end else begin
                            rx_sum   <= rx_byte;
                            rx_cnt   <= LAST_IDX;
                            rx_state <= R_DATA;
                        end
                    end
                    R_DATA: begin
                        // Shift in from the top so byte 0 ends up in bits [7:0].
                        rx_shadow <= (rx_shadow >> 8) | (PW'(rx_byte) << (PW-8));
                        rx_sum    <= rx_sum + rx_byte;
                        if (rx_cnt == '0)
                            rx_state <= R_SUM;
                        else
                            rx_cnt <= rx_cnt - 8'd1;
                    end
                    R_SUM: begin
                        if (sum_good) begin
                            rx_payload     <= rx_shadow;
                            rx_frame_valid <= 1'b1;
                        end
                        rx_state <= R_HUNT;
                    end
                    default: rx_state <= R_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pong_state_link.sv
`timescale 1ns/1ps
module tb_pong_state_link;

    localparam int N   = 6;
    localparam int BT  = 20;
    localparam int LT  = 400;
    localparam int NV  = 7;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [7:0]  b [11];
        int          n;
        int          frames_inc;
        int          err_inc;
        logic [47:0] payload;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          send;
    logic [47:0]   tx_payload;
    logic [7:0]    tx_byte;
    logic          tx_byte_valid;
    logic          tx_byte_ready;
    logic          tx_busy;
    logic [7:0]    rx_byte;
    logic          rx_byte_valid;
    logic [47:0]   rx_payload;
    logic          rx_frame_valid;
    logic          link_ok;
    logic [7:0]    err_count;

    pong_state_link #(
        .PAYLOAD_BYTES(N),
        .SYNC_BYTE    (8'hA5),
        .BYTE_TIMEOUT (BT),
        .LINK_TIMEOUT (LT),
        .ERR_W        (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .send          (send),
        .tx_payload    (tx_payload),
        .tx_byte       (tx_byte),
        .tx_byte_valid (tx_byte_valid),
        .tx_byte_ready (tx_byte_ready),
        .tx_busy       (tx_busy),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .rx_payload    (rx_payload),
        .rx_frame_valid(rx_frame_valid),
        .link_ok       (link_ok),
        .err_count     (err_count)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rx_pulses = 0;
    logic [7:0]  tx_q[$];
    logic [8:0]  rx_script[$];
    logic        rand_ready = 0;
    logic        ready_hold = 1;
    logic        loopback   = 0;
    logic [8:0]  drv_e;

    // reference model state
    int          exp_err = 0;
    int          exp_frames = 0;
    logic [47:0] exp_payload = '0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    // input driver: ready + rx bytes, all changed on the falling edge
    initial begin
        tx_byte_ready = 1'b0;
        rx_byte       = 8'h00;
        rx_byte_valid = 1'b0;
        forever begin
            @(negedge clk);
            tx_byte_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
            if (loopback) begin
                rx_byte       = tx_byte;
                rx_byte_valid = tx_byte_valid & tx_byte_ready;
            end else if (rx_script.size() > 0) begin
                drv_e         = rx_script.pop_front();
                rx_byte_valid = drv_e[8];
                rx_byte       = drv_e[7:0];
            end else begin
                rx_byte_valid = 1'b0;
            end
        end
    end

    // output monitor
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && tx_byte_valid && tx_byte_ready) tx_q.push_back(tx_byte);
            if (rx_frame_valid) rx_pulses++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no event within budget required event", nm);
    endtask

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    function automatic bq_t make_frame(input logic [47:0] p);
        bq_t q;
        int  s;
        q = {};
        q.push_back(8'hA5);
        q.push_back(8'(N));
        s = N;
        for (int i = 0; i < N; i++) begin
            q.push_back(p[8*i +: 8]);
            s = s + int'(p[8*i +: 8]);
        end
        q.push_back(8'(s % 256));
        return q;
    endfunction

    task automatic script(input bq_t q, input int gap_max);
        for (int i = 0; i < q.size(); i++) begin
            rx_script.push_back({1'b1, q[i]});
            if (gap_max > 0 && i < q.size() - 1) begin
                int g;
                g = $urandom_range(0, gap_max);
                for (int j = 0; j < g; j++) rx_script.push_back(9'h000);
            end
        end
    endtask

    task automatic silence(input int cycles);
        for (int j = 0; j < cycles; j++) rx_script.push_back(9'h000);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (rx_script.size() != 0 && k < 2000) begin
            tick();
            k++;
        end
        if (rx_script.size() != 0) timeout_fail("rx_drain");
        repeat (3) tick();
    endtask

    task automatic wait_txq(input int target, input string nm);
        int k;
        k = 0;
        while (tx_q.size() < target && k < 300) begin
            tick();
            k++;
        end
        if (tx_q.size() < target) timeout_fail(nm);
    endtask

    task automatic pulse_send(input logic [47:0] p);
        tx_payload = p;
        send = 1'b1;
        tick();
        send = 1'b0;
    endtask

    task automatic check_model(input string nm);
        chk({nm, "_payload"}, rx_payload, exp_payload);
        chk({nm, "_err"}, err_count, exp_err);
        chk({nm, "_frames"}, rx_pulses, exp_frames);
    endtask

    vec_t        vecs[NV];
    bq_t         q;
    bq_t         q2;
    int          base;
    logic [47:0] p;
    logic [47:0] p2;
    logic [7:0]  jb;
    int          kind;
    int          k;

    initial begin
        rst_n      = 1'b0;
        send       = 1'b0;
        tx_payload = '0;

        vecs[0] = '{'{8'hA5,8'h06,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h1B,8'h00,8'h00}, 9, 1, 0, 48'h060504030201};
        vecs[1] = '{'{8'hA5,8'h06,8'h11,8'h12,8'h13,8'h14,8'h15,8'h16,8'h7C,8'h00,8'h00}, 9, 0, 1, 48'h060504030201};
        vecs[2] = '{'{8'hA5,8'h05,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 0, 1, 48'h060504030201};
        vecs[3] = '{'{8'h00,8'hFF,8'h5A,8'h06,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 4, 0, 0, 48'h060504030201};
        vecs[4] = '{'{8'hA5,8'h06,8'h10,8'h20,8'h30,8'h40,8'h50,8'h60,8'h56,8'h00,8'h00}, 9, 1, 0, 48'h605040302010};
        vecs[5] = '{'{8'hA5,8'h06,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'h00,8'h00,8'h00}, 9, 1, 0, 48'hFFFFFFFFFFFF};
        vecs[6] = '{'{8'hA5,8'h06,8'h11,8'h12,8'h13,8'h14,8'h15,8'h16,8'h7B,8'h00,8'h00}, 9, 1, 0, 48'h161514131211};

        repeat (3) tick();
        chk("reset_ctrl", {tx_byte, tx_byte_valid, tx_busy, rx_frame_valid, link_ok, err_count}, 64'h0);
        chk("reset_rx_payload", rx_payload, 48'h0);
        rst_n = 1'b1;
        tick();

        // basic TX, first held off by ready=0
        ready_hold = 1'b0;
        pulse_send(48'h060504030201);
        repeat (3) tick();
        chk("stall_valid_held", {tx_byte_valid, tx_byte}, {1'b1, 8'hA5});
        chk("stall_busy", tx_busy, 1'b1);
        base = tx_q.size();
        ready_hold = 1'b1;
        q = make_frame(48'h060504030201);
        wait_txq(base + 9, "t1_bytes_wait");
        tick();
        chk("t1_busy_after", tx_busy, 1'b0);
        chk("t1_sum_byte", tx_q[base + 8], 8'h1B);
        for (int i = 0; i < 9; i++) chk($sformatf("t1_byte%0d", i), tx_q[base + i], q[i]);

        // two sends 3 cycles apart plus a third mid-frame: exactly two frames
        base = tx_q.size();
        p  = 48'hC0FFEE123456;
        p2 = 48'h0102030405AA;
        pulse_send(p);
        repeat (2) tick();
        pulse_send(p2);
        repeat (4) tick();
        pulse_send(p2);
        wait_txq(base + 18, "t6_bytes_wait");
        repeat (30) tick();
        chk("t6_byte_count", tx_q.size() - base, 18);
        chk("t6_busy_after", tx_busy, 1'b0);
        q = make_frame(p);
        q2 = make_frame(p2);
        for (int i = 0; i < 9; i++) q.push_back(q2[i]);
        k = 0;
        for (int i = 0; i < 18 && base + i < tx_q.size(); i++)
            if (tx_q[base + i] !== q[i]) k++;
        chk("t6_stream_mismatches", k, 0);

        // loopback with random ready stalls
        loopback   = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 12; f++) begin
            base = tx_q.size();
            p = 48'({$urandom(), $urandom()});
            pulse_send(p);
            k = 0;
            while (rx_pulses < exp_frames + 1 && k < 300) begin
                tick();
                k++;
            end
            if (rx_pulses < exp_frames + 1) timeout_fail("loop_frame_wait");
            exp_frames++;
            exp_payload = p;
            check_model($sformatf("loop%0d", f));
            q = make_frame(p);
            k = 0;
            for (int i = 0; i < 9 && base + i < tx_q.size(); i++)
                if (tx_q[base + i] !== q[i]) k++;
            chk($sformatf("loop%0d_txbytes", f), k + (9 - (tx_q.size() - base)), 0);
            tick();
        end
        chk("loop_link_ok", link_ok, 1'b1);
        rand_ready = 1'b0;
        loopback   = 1'b0;
        repeat (2) tick();

        // table-driven RX vectors
        for (int v = 0; v < NV; v++) begin
            q = {};
            for (int i = 0; i < vecs[v].n; i++) q.push_back(vecs[v].b[i]);
            base = rx_pulses;
            script(q, 0);
            drain();
            exp_err    += vecs[v].err_inc;
            exp_frames += vecs[v].frames_inc;
            chk($sformatf("vec%0d_frames", v), rx_pulses - base, vecs[v].frames_inc);
            chk($sformatf("vec%0d_err", v), err_count, exp_err);
            chk($sformatf("vec%0d_payload", v), rx_payload, vecs[v].payload);
            if (vecs[v].frames_inc != 0) exp_payload = vecs[v].payload;
        end

        // byte timeout: A5,06,01 then BT+1 silent cycles
        q = '{8'hA5, 8'h06, 8'h01};
        script(q, 0);
        silence(BT + 1);
        drain();
        exp_err++;
        check_model("timeout_abort");
        p = 48'h0A0B0C0D0E0F;
        script(make_frame(p), 0);
        drain();
        exp_frames++;
        exp_payload = p;
        check_model("timeout_recover");

        // gap of BT-1 cycles: next byte lands on the expiry cycle and must win
        p = 48'h111122223333;
        q = make_frame(p);
        rx_script.push_back({1'b1, q[0]});
        rx_script.push_back({1'b1, q[1]});
        silence(BT - 1);
        for (int i = 2; i < 9; i++) rx_script.push_back({1'b1, q[i]});
        drain();
        exp_frames++;
        exp_payload = p;
        check_model("gap_byte_wins");

        // link_ok holds for LT cycles after a good frame, then drops
        p = 48'h5A5A00FF1234;
        script(make_frame(p), 0);
        k = 0;
        while (rx_frame_valid !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        if (rx_frame_valid !== 1'b1) timeout_fail("link_frame_wait");
        exp_frames++;
        exp_payload = p;
        chk("link_set", link_ok, 1'b1);
        repeat (LT - 1) tick();
        chk("link_hold_last", link_ok, 1'b1);
        tick();
        chk("link_drop", link_ok, 1'b0);
        check_model("link");

        // randomized RX stream against the model
        for (int f = 0; f < 30; f++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h00;
                rx_script.push_back({1'b1, jb});
            end
            kind = $urandom_range(0, 3);
            p = 48'({$urandom(), $urandom()});
            q = make_frame(p);
            if (kind == 2) begin
                q[8] = q[8] + 8'd1;
                exp_err++;
            end else if (kind == 3) begin
                q = '{8'hA5, 8'($urandom_range(7, 255))};
                exp_err++;
            end else begin
                exp_frames++;
                exp_payload = p;
            end
            script(q, 4);
            drain();
            check_model($sformatf("rand%0d_k%0d", f, kind));
        end

        // err_count saturation
        for (int j = 0; j < 300; j++) begin
            rx_script.push_back({1'b1, 8'hA5});
            rx_script.push_back({1'b1, 8'h07});
        end
        drain();
        exp_err = (exp_err + 300 > 255) ? 255 : exp_err + 300;
        chk("sat_err", err_count, 8'hFF);
        check_model("sat");

        // asynchronous reset in the middle of a TX frame
        pulse_send(48'h123456789ABC);
        repeat (3) tick();
        chk("mid_busy", tx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctrl", {tx_byte, tx_byte_valid, tx_busy, rx_frame_valid, link_ok, err_count}, 64'h0);
        chk("rst_async_payload", rx_payload, 48'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", {tx_byte_valid, tx_busy, err_count}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
